// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and helpers for the register-file write-back arbiter.
//   REG_ZERO      - address of the hard-wired zero register (never written)
//   NREQ_DEF/AW_DEF/DW_DEF - default requester count, address width, data width
//   GIDW          - width of the grant_id output
//   get_slice()   - extract field idx (width w) from a packed vector
package wb_pkg;

  localparam int NREQ_DEF = 3;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int REG_ZERO = 0;
  localparam int GIDW     = 3;

  // get_slice works on a fixed-width carrier so one function serves both the
  // address and data buses; callers widen the bus and truncate the result.
  localparam int SLICE_VW   = 512;
  localparam int SLICE_MAXW = 256;

  function automatic logic [SLICE_MAXW-1:0] get_slice(
    input logic [SLICE_VW-1:0] vec,
    input int unsigned         idx,
    input int unsigned         w
  );
    logic [SLICE_VW-1:0]   shifted;
    logic [SLICE_MAXW-1:0] mask;
    shifted   = vec >> (idx * w);
    mask      = (SLICE_MAXW'(1) << w) - SLICE_MAXW'(1);
    get_slice = SLICE_MAXW'(shifted) & mask;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: write-back bus between the producers and the arbiter,
// plus the arbiter's register-file write port.
//   req_valid/req_addr/req_data - per-requester write requests (packed)
//   req_ready                   - per-requester accept (one-hot or zero)
//   WE/WA/WD                    - registered register-file write port
//   grant_id                    - requester index issued on WE
//   busy                        - OR of req_valid
// master: requester/register-file side, slave: arbiter side.
interface regfile_wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               WE;
  logic [AW-1:0]      WA;
  logic [DW-1:0]      WD;
  logic [GIDW-1:0]    grant_id;
  logic               busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, WE, WA, WD, grant_id, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, WE, WA, WD, grant_id, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req_i       - request vector
//   last_i      - index granted most recently (priority pointer)
//   grant_o     - one-hot grant, zero when no request
//   grant_idx_o - index of the granted requester (0 when no request)
// The search starts at last_i+1 and wraps mod N, so last_i has lowest priority.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [LW-1:0] grant_idx_o
);

  int   idx;
  logic found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_i) + k) % N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = LW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// NREQ write-back producers with round-robin arbitration.
//   clk  - clock, rising-edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of regfile_wb_arbiter_if (requests in, ready and the
//          registered WE/WA/WD/grant_id out, combinational busy)
// The accepted write is registered and issued one cycle after the handshake.
// Writes addressed to register 0 are accepted (ready, pointer advances) but
// never raise WE, so $zero stays 0.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant;
  logic [LW-1:0]   grant_idx;
  logic            xfer;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  logic [LW-1:0]   last_q, last_d;
  logic            we_q, we_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic [GIDW-1:0] gid_q, gid_d;

  rr_arbiter #(.N(NREQ), .LW(LW)) u_rr (
    .req_i       (bus.req_valid),
    .last_i      (last_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Ready is the grant itself; a transfer happens whenever anyone is granted.
  assign xfer     = |grant;
  assign win_addr = AW'(get_slice(SLICE_VW'(bus.req_addr), 32'(grant_idx), AW));
  assign win_data = DW'(get_slice(SLICE_VW'(bus.req_data), 32'(grant_idx), DW));

  always_comb begin
    last_d = last_q;
    we_d   = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    gid_d  = gid_q;
    if (xfer) begin
      last_d = grant_idx;
      if (win_addr != AW'(REG_ZERO)) begin
        we_d  = 1'b1;
        wa_d  = win_addr;
        wd_d  = win_data;
        gid_d = GIDW'(grant_idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= LW'(NREQ - 1);
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      gid_q  <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      gid_q  <= gid_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.WE        = we_q;
  assign bus.WA        = wa_q;
  assign bus.WD        = wd_q;
  assign bus.grant_id  = gid_q;
  assign bus.busy      = |bus.req_valid;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Round-robin write-back arbiter that shares the register file's single write port (write enable, write address, write data) between NREQ producers: ALU, load unit, multiply/divide unit. Each producer hands off one write per valid/ready handshake. The block registers the winning write and drives it to the register file one cycle later. Writes to register 0 are accepted but never issued, which keeps `$zero` constant at 0.

## Interface
Parameters:
- NREQ, 3, number of write-back requesters (2..8)
- AW, 5, register address width
- DW, 32, register data width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NREQ  bit i: requester i has a write pending
- req_addr  input  NREQ*AW  requester i address in bits [i*AW +: AW]
- req_data  input  NREQ*DW  requester i data in bits [i*DW +: DW]
- req_ready  output  NREQ  one-hot or zero; bit i: requester i's write accepted this cycle
- WE  output  1  register file write enable (registered)
- WA  output  AW  register file write address (registered)
- WD  output  DW  register file write data (registered)
- grant_id  output  3  index of the requester issued on WE (registered; valid when WE=1)
- busy  output  1  OR of req_valid (combinational)

## Operation
- Handshake:
  - A transfer occurs on a rising edge where req_valid[i] and req_ready[i] are both 1.
  - Once req_valid[i] is raised, the requester holds req_valid[i], req_addr and req_data stable until the transfer.
  - The arbiter never lowers ready on an asserted valid except through arbitration loss.
- Arbitration:
  - req_ready is combinational from req_valid and the priority pointer `last`.
  - At most one ready bit is high per cycle. If any valid is high, exactly one ready is high.
  - The winner is the first valid requester searching (last+1, last+2, …) mod NREQ.
- Pointer:
  - On a transfer, `last` ← winner index.
  - With no transfer, `last` holds.
  - Reset value of `last` is NREQ-1, so requester 0 has top priority after reset.
- Issue register, on each rising edge:
  - Transfer with addr ≠ 0: WE←1, WA←addr, WD←data, grant_id←winner.
  - Transfer with addr = 0: WE←0. WA, WD and grant_id hold. The pointer still advances.
  - No transfer: WE←0. WA, WD and grant_id hold.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once in every NREQ consecutive cycles.
- Throughput: one write per cycle, with no bubble between back-to-back grants.
- Arithmetic: pointer increments mod NREQ (wrap NREQ-1 → 0). No data arithmetic is performed; data and address are passed bit-exact.

## Timing
- Reset values (asserted asynchronously, released synchronously by the environment):
  - WE=0, WA=0, WD=0, grant_id=0, last=NREQ-1.
  - req_ready follows the combinational rule using last=NREQ-1.
- Latency:
  - A transfer at edge N drives WE/WA/WD during cycle N→N+1.
  - The register file captures the write at edge N+1.
  - A value is therefore readable from the register file's asynchronous read ports after edge N+1, i.e. 2 edges after handshake.
- Simultaneous valid: losers see ready=0 and wait. The maximum wait for any requester is NREQ-1 cycles.
- Same address from two requesters in consecutive grants: both writes issue in grant order, and the later one wins in the register file.
- Reset mid-operation:
  - Any write held in WE/WA/WD is dropped.
  - Requesters' held values are not consumed.
  - After release, requester 0 has top priority.
- valid rising in the same cycle as reset release: eligible for grant on the first edge after release.

## Structure
- Shared package `wb_pkg`:
  - constants REG_ZERO = 0, AW, DW defaults;
  - function to extract slice i of a packed vector.
- Sub-module `rr_arbiter`:
  - parameter N;
  - inputs req[N] and last;
  - outputs onehot grant and grant index (combinational).
- Top level `regfile_wb_arbiter` holds the pointer register, issue register and zero-address suppression.

## Test plan
- Single requester 1, addr 8, data 0x0000_00AA, valid one cycle → req_ready[1]=1 that cycle; next cycle WE=1, WA=8, WD=0xAA, grant_id=1; register file reg 8 = 0xAA after following edge.
- All 3 valid continuously for 6 cycles right after reset → grant order 0,1,2,0,1,2; WE=1 every cycle from cycle 2 on.
- Requester 0 writes addr 0, data 0xFFFF_FFFF → ready=1, WE stays 0, reg 0 reads 0, next grant goes to requester 1 if valid.
- Requesters 1 and 2 both write addr 9 (data 5 then 7) in consecutive grants → WE pulses twice; reg 9 = 7 at end.
- Assert rst while a write is in the issue register (WE=1) → WE=0, WA=0, WD=0 immediately (asynchronous); the write does not occur; after release, requester 0 is granted first over 1 and 2.
- Requester 2 valid alone while 0/1 idle, then 0 raises valid while 2 still valid with last=2 → requester 0 is granted next, 2 waits, and 2 is granted the following cycle.
